// File: rtl/nios_debug_scan_pkg.sv
// Shared types and constants for the Nios II debug-slave scan master.
package nios_debug_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    RSP
  } state_t;

  localparam int DR_WIDTH_DEFAULT = 38;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

endpackage

// File: rtl/nios_debug_scan_tckgen.sv
// Test-clock generator: divides clk by 2*TCK_HALF while run is high and
// flags the clk cycle on which tck rises or falls.
module nios_debug_scan_tckgen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] HALF_LAST = 8'(TCK_HALF - 1);

  logic [7:0] cnt;
  logic       wrap;

  assign wrap = run && (cnt == HALF_LAST);
  assign rise = wrap && !tck;
  assign fall = wrap && tck;

  // Dropping run parks tck low with the divider cleared for the next command.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/nios_debug_scan_master.sv
// Virtual-JTAG initiator: runs one UIR/CDR/SDR/UDR/RTI debug transaction per
// accepted command and returns the captured data register.
module nios_debug_scan_master
  import nios_debug_scan_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int IR_WIDTH = 2,
  parameter int TCK_HALF = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_rti,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr
);

  localparam int            BW       = $clog2(DR_WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH);

  state_t              state, state_nxt;
  logic                run, rise, fall, accept;
  logic [DR_WIDTH-1:0] shreg;
  logic [BW-1:0]       bit_cnt;

  nios_debug_scan_tckgen #(.TCK_HALF(TCK_HALF)) u_tckgen (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .tck  (vji_tck),
    .rise (rise),
    .fall (fall)
  );

  assign run    = (state != IDLE) && (state != RSP);
  assign accept = cmd_valid && (state == IDLE);

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign vji_uir   = (state == UIR);
  assign vji_cdr   = (state == CDR);
  assign vji_sdr   = (state == SDR);
  assign vji_udr   = (state == UDR);
  assign vji_rti   = (state == RTI) || (state == IDLE) || (state == RSP);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Every shift state advances only on the tck fall that closes its period.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = UIR;
      UIR:     if (fall) state_nxt = CDR;
      CDR:     if (fall) state_nxt = SDR;
      SDR:     if (fall && (bit_cnt == BIT_LAST)) state_nxt = UDR;
      UDR:     if (fall) state_nxt = RTI;
      RTI:     if (fall) state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vji_ir_in  <= '0;
      vji_tdi    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
    end else begin
      if (accept) begin
        vji_ir_in <= cmd_ir;
        shreg     <= cmd_dr;
      end
      case (state)
        UIR: begin
          if (rise) rsp_ir_out <= vji_ir_out;
          if (fall) vji_tdi <= shreg[0];
        end
        CDR: begin
          if (fall) begin
            vji_tdi <= shreg[0];
            bit_cnt <= '0;
          end
        end
        SDR: begin
          // tdo is taken on the rise, the next tdi bit is presented on the fall.
          if (rise) begin
            shreg   <= {vji_tdo, shreg[DR_WIDTH-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
          end
          if (fall) vji_tdi <= (bit_cnt == BIT_LAST) ? 1'b0 : shreg[0];
        end
        RTI: begin
          if (fall) rsp_dr <= shreg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_debug_scan_master.sv
// Bench for nios_debug_scan_master: transaction-level timing model checked
// every cycle, a behavioural debug slave, and literal expectations.
module tb_nios_debug_scan_master;
  import nios_debug_scan_pkg::*;

  localparam int DRW   = 38;
  localparam int IRW   = 2;
  localparam int H     = 2;
  localparam int TOTAL = (DRW + 4) * 2 * H;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [IRW-1:0] cmd_ir = '0;
  logic [DRW-1:0] cmd_dr = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DRW-1:0] rsp_dr;
  logic [IRW-1:0] rsp_ir_out;
  logic           vji_tck, vji_tdi, vji_tdo;
  logic [IRW-1:0] vji_ir_in;
  logic [IRW-1:0] vji_ir_out = '0;
  logic           vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;

  logic           f_cmd_valid = 1'b0;
  logic           f_cmd_ready;
  logic [IRW-1:0] f_cmd_ir = '0;
  logic [DRW-1:0] f_cmd_dr = '0;
  logic           f_rsp_valid;
  logic           f_rsp_ready = 1'b1;
  logic [DRW-1:0] f_rsp_dr;
  logic [IRW-1:0] f_rsp_ir_out;
  logic           f_tck, f_tdi;
  logic           f_tdo = 1'b1;
  logic [IRW-1:0] f_ir_in;
  logic [IRW-1:0] f_ir_out = '0;
  logic           f_rti, f_uir, f_cdr, f_sdr, f_udr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nios_debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(H)) dut (
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi),
    .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_rti(vji_rti), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr)
  );

  nios_debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(1)) u_fast (
    .clk(clk), .reset(rst), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_ir(f_cmd_ir), .cmd_dr(f_cmd_dr), .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready),
    .rsp_dr(f_rsp_dr), .rsp_ir_out(f_rsp_ir_out), .vji_tck(f_tck), .vji_tdi(f_tdi),
    .vji_tdo(f_tdo), .vji_ir_in(f_ir_in), .vji_ir_out(f_ir_out),
    .vji_rti(f_rti), .vji_uir(f_uir), .vji_cdr(f_cdr), .vji_sdr(f_sdr),
    .vji_udr(f_udr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", nm, $time, act, exp);
    end
  endtask

  // Debug slave: loopback (tdo = tdi one tck late) or a shift register
  // loaded at the UIR rise and shifted on each SDR rise.
  logic           lb_mode = 1'b1;
  logic           lb_q = 1'b0;
  logic [DRW-1:0] sr = '0;
  logic [DRW-1:0] sr_preset = '0;
  int             sdr_rise_tot = 0;

  assign vji_tdo = lb_mode ? lb_q : sr[0];

  initial begin
    forever begin
      @(posedge vji_tck);
      lb_q = vji_tdi;
      if (vji_uir) sr = sr_preset;
      else if (vji_sdr) begin
        sr = {vji_tdi, sr[DRW-1:1]};
        sdr_rise_tot++;
      end
    end
  end

  // Transaction model: m_n counts clk edges since the accepting edge; one
  // tck period is 2*H edges, periods are UIR, CDR, DRW x SDR, UDR, RTI.
  logic           m_started = 1'b0;
  logic           m_busy = 1'b0;
  logic           m_rsp = 1'b0;
  int             m_n = 0;
  logic [DRW-1:0] m_dr = '0;
  logic [DRW-1:0] m_cap = '0;
  logic [DRW-1:0] m_rsp_dr = '0;
  logic [IRW-1:0] m_ir_in = '0;
  logic [IRW-1:0] m_ir_out = '0;

  initial begin
    int q, p;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_started = 1'b1;
        m_busy = 1'b0; m_rsp = 1'b0; m_n = 0;
        m_rsp_dr = '0; m_ir_in = '0; m_ir_out = '0;
      end else if (m_busy) begin
        m_n++;
        if (m_n == H) m_ir_out = vji_ir_out;
        q = m_n - H;
        if (q >= 0 && (q % (2 * H)) == 0) begin
          p = q / (2 * H);
          if (p >= 2 && p <= DRW + 1) m_cap[p-2] = vji_tdo;
        end
        if (m_n == TOTAL) begin
          m_busy = 1'b0; m_rsp = 1'b1; m_rsp_dr = m_cap;
        end
      end else if (m_rsp) begin
        if (rsp_ready) m_rsp = 1'b0;
      end else if (cmd_valid) begin
        m_busy = 1'b1; m_n = 0; m_dr = cmd_dr; m_ir_in = cmd_ir; m_cap = '0;
      end
    end
  end

  initial begin
    int p;
    logic e_tck, e_uir, e_cdr, e_sdr, e_udr, e_rti, e_tdi;
    forever begin
      @(negedge clk);
      if (m_started) begin
        e_tck = 0; e_uir = 0; e_cdr = 0; e_sdr = 0; e_udr = 0; e_rti = 1; e_tdi = 0;
        if (m_busy) begin
          p = m_n / (2 * H);
          e_tck = ((m_n / H) % 2) == 1;
          e_rti = 0;
          if (p == 0) e_uir = 1;
          else if (p == 1) begin e_cdr = 1; e_tdi = m_dr[0]; end
          else if (p <= DRW + 1) begin e_sdr = 1; e_tdi = m_dr[p-2]; end
          else if (p == DRW + 2) e_udr = 1;
          else e_rti = 1;
        end
        chk("cmd_ready", cmd_ready, !m_busy && !m_rsp);
        chk("rsp_valid", rsp_valid, m_rsp);
        chk("vji_tck", vji_tck, e_tck);
        chk("vji_uir", vji_uir, e_uir);
        chk("vji_cdr", vji_cdr, e_cdr);
        chk("vji_sdr", vji_sdr, e_sdr);
        chk("vji_udr", vji_udr, e_udr);
        chk("vji_rti", vji_rti, e_rti);
        chk("vji_tdi", vji_tdi, e_tdi);
        chk("vji_ir_in", vji_ir_in, m_ir_in);
        chk("rsp_dr", rsp_dr, m_rsp_dr);
        chk("rsp_ir_out", rsp_ir_out, m_ir_out);
      end
    end
  end

  task automatic do_cmd(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr, output int lat);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, base, hi, cnt_a, cnt_b, cnt_c, cnt_d;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    hi = 0;
    repeat (20) begin
      @(negedge clk);
      hi += int'(vji_tck);
    end
    chk("idle_tck_highs", hi, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_rti", vji_rti, 1);
    chk("idle_states", {vji_uir, vji_cdr, vji_sdr, vji_udr}, 4'b0000);

    // Loopback: captured word is {dr[36:0], dr[0]}.
    lb_mode = 1'b1; rsp_ready = 1'b1;
    base = sdr_rise_tot;
    do_cmd(IR_BREAK, 38'h2A_5A5A_C3C3, lat);
    chk("lat_default", lat, 168);
    chk("loop_rsp_dr", rsp_dr, 38'h14_B4B5_8787);
    chk("loop_ir_in", vji_ir_in, 2'b10);
    chk("loop_sdr_rises", sdr_rise_tot - base, 38);
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("ready_after_rsp", cmd_ready, 1);

    // Slave shift register, response stalled for 50 cycles.
    lb_mode = 1'b0; sr_preset = 38'h3F_0000_0001; vji_ir_out = 2'b01; rsp_ready = 1'b0;
    do_cmd(IR_TRACEMEM, '0, lat);
    chk("lat_stall_txn", lat, 168);
    chk("slave_rsp_dr", rsp_dr, 38'h3F_0000_0001);
    chk("slave_ir_out", rsp_ir_out, 2'b01);
    chk("slave_sr_got_dr", sr, 38'h0);
    cmd_valid = 1'b1; cmd_ir = IR_TRACECTRL; cmd_dr = 38'h15_5555_5555;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    repeat (50) begin
      @(negedge clk);
      cnt_a += int'(vji_tck);
      cnt_b += int'(!rsp_valid);
      cnt_c += int'(rsp_dr != 38'h3F_0000_0001);
      cnt_d += int'(cmd_ready);
    end
    chk("stall_tck_highs", cnt_a, 0);
    chk("stall_rsp_drops", cnt_b, 0);
    chk("stall_rsp_dr_changes", cnt_c, 0);
    chk("stall_ready_highs", cnt_d, 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_after_pulse", cmd_ready, 1);
    chk("valid_after_pulse", rsp_valid, 0);

    // Reset in the middle of SDR, then a clean transaction.
    lb_mode = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = IR_TRACECTRL; cmd_dr = 38'h3F_FFFF_FFFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    base = sdr_rise_tot; cnt_a = 0;
    while ((sdr_rise_tot - base) < 17 && cnt_a < 400) begin
      @(negedge clk);
      cnt_a++;
    end
    chk("reached_sdr_bit17", sdr_rise_tot - base, 17);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs",
        {cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr},
        9'b1_0001_0000);
    chk("abort_ir_in", vji_ir_in, 2'b00);
    chk("abort_rsp_dr", rsp_dr, 38'h0);
    chk("abort_rsp_ir_out", rsp_ir_out, 2'b00);
    cnt_b = 0;
    repeat (30) begin
      @(negedge clk);
      cnt_b += int'(rsp_valid);
    end
    chk("abort_no_rsp", cnt_b, 0);
    do_cmd(IR_TRACECTRL, 38'h01_2345_6789, lat);
    chk("lat_after_abort", lat, 168);
    chk("after_abort_rsp_dr", rsp_dr, 38'h02_468A_CF13);
    chk("after_abort_ir_in", vji_ir_in, 2'b11);

    // TCK_HALF=1 instance, tdo tied high.
    @(negedge clk);
    f_cmd_valid = 1'b1; f_cmd_ir = IR_OCIMEM; f_cmd_dr = 38'h0A_0000_0005;
    @(posedge clk);
    @(negedge clk);
    f_cmd_valid = 1'b0;
    lat = 0;
    while (!f_rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("lat_fast", lat, 84);
    chk("fast_rsp_dr", f_rsp_dr, 38'h3F_FFFF_FFFF);
    @(negedge clk);
    chk("fast_idle",
        {f_cmd_ready, f_rsp_valid, f_tck, f_tdi, f_rti, f_uir, f_cdr, f_sdr, f_udr},
        9'b1_0001_0000);
    chk("fast_ir", {f_ir_in, f_rsp_ir_out}, 4'b0000);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nios_debug_scan_master.md
Name: nios_debug_scan_master

Overview:
- On-chip initiator for the Nios II debug-slave virtual-JTAG interface.
- Drives the tck/tdi/ir_in/virtual-state signals that the debug slave's tck-domain logic consumes, and captures its tdo/ir_out.
- Lets a system-clock agent (test sequencer, bring-up FSM) issue one IR+DR debug transaction per command without a physical JTAG cable.
- Sits beside the CPU debug slave and replaces the sld_virtual_jtag_basic hub connection in self-test builds.

Parameters:
- DR_WIDTH, 38, debug data-register length in bits; equals the slave's sr/jdo width.
- IR_WIDTH, 2, virtual IR width.
- TCK_HALF, 2, clk cycles per tck half-period; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block is idle and accepts a command this cycle.
- cmd_ir  in  IR_WIDTH  IR value for the transaction.
- cmd_dr  in  DR_WIDTH  data shifted out, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_dr  out  DR_WIDTH  data captured from tdo.
- rsp_ir_out  out  IR_WIDTH  ir_out sampled during the UIR period.
- vji_tck  out  1  generated test clock, registered.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  virtual IR to the slave.
- vji_ir_out  in  IR_WIDTH  virtual IR status from the slave.
- vji_rti  out  1  run-test/idle state indicator.
- vji_uir  out  1  update-IR virtual state.
- vji_cdr  out  1  capture-DR virtual state.
- vji_sdr  out  1  shift-DR virtual state.
- vji_udr  out  1  update-DR virtual state.

Behaviour:
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir_out=0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0, vji_rti=1.
  - vji_uir, vji_cdr, vji_sdr, vji_udr all 0.
  - FSM=IDLE, tck counter=0.
- Reset mid-transaction aborts on the next edge with no response; the slave sees tck stop low and rti=1.
- tck generation:
  - Counter runs only outside IDLE/RSP.
  - vji_tck toggles when the counter reaches TCK_HALF-1; the counter then clears. One tck period = 2*TCK_HALF clk.
  - "rise" = cycle where tck goes 0->1; "fall" = 1->0.
  - In IDLE and RSP, tck is held 0.
- Acceptance: cmd_valid&&cmd_ready latches cmd_ir into vji_ir_in and cmd_dr into shreg, deasserts cmd_ready, and enters UIR with tck low.
- All vji_* state outputs and tdi change only on the fall that ends a state. Each state lasts whole tck periods.
- FSM:
  - UIR (1 period): vji_uir=1, rti=0. vji_ir_out is sampled into rsp_ir_out at the rise.
  - CDR (1 period): vji_cdr=1; vji_tdi=shreg[0].
  - SDR (DR_WIDTH periods):
    - vji_sdr=1.
    - Each rise: shreg <= {vji_tdo, shreg[DR_WIDTH-1:1]}.
    - Each fall: vji_tdi <= new shreg[0].
    - A bit counter counts DR_WIDTH rises.
  - UDR (1 period): vji_udr=1, vji_tdi=0.
  - RTI (1 period): vji_rti=1. At its fall: rsp_dr <= shreg, rsp_valid=1, go to RSP.
  - RSP: tck stops. Hold until rsp_valid&&rsp_ready, then go to IDLE with cmd_ready=1 on the next cycle.
- Exactly one of uir/cdr/sdr/udr/rti is high at any time outside IDLE/RSP. In IDLE/RSP only rti is high.
- vji_ir_in holds the last command's IR after completion; the slave's sysclk side decodes it at udr.
- Latency: rsp_valid rises exactly (DR_WIDTH+4)*2*TCK_HALF clk after the accepting cycle (168 at defaults).
- cmd_valid during busy is ignored (cmd_ready=0); there is no queueing.
- rsp_ready may be held high permanently: RSP then lasts exactly 1 cycle.

Decomposition:
- Package nios_debug_scan_pkg:
  - state enum {IDLE, UIR, CDR, SDR, UDR, RTI, RSP}.
  - DR_WIDTH_DEFAULT=38.
  - IR codes: IR_OCIMEM=2'b00, IR_TRACEMEM=2'b01, IR_BREAK=2'b10, IR_TRACECTRL=2'b11.
- One sub-module: nios_debug_scan_tckgen (counter, tck register, rise/fall pulses, run enable).

Test Plan:
- Reset then idle 20 cycles -> cmd_ready=1, vji_rti=1, vji_tck constantly 0, all other vji_* state outputs 0.
- Loopback (vji_tdo=vji_tdi delayed one tck), cmd_ir=2'b10, cmd_dr=38'h2A_5A5A_C3C3 -> rsp_dr equals the bench's serial model prediction, vji_ir_in=2'b10; 38 tck rises counted while vji_sdr=1.
- Bench slave sr model preloaded 38'h3F_0000_0001, cmd_dr=0 -> rsp_dr=38'h3F_0000_0001; vji_ir_out=2'b01 during UIR -> rsp_ir_out=2'b01.
- Default params, accept at cycle T -> rsp_valid first high at T+168; with TCK_HALF=1 -> T+84.
- rsp_ready held 0 for 50 cycles -> rsp_valid and rsp_dr stable, tck stays 0, cmd_valid ignored; one rsp_ready pulse -> cmd_ready=1 next cycle.
- reset asserted during SDR bit 17 -> next cycle all outputs at reset values, no rsp_valid; a new command then completes normally.
